axis_flit_rx_buffer: RTL
========================

// Module: axis_flit_rx_buffer
// PURPOSE
//  Flit FIFO between the NoC OutPortSimple receive port and the AXI4-Stream slave bridge.
//  Decouples NoC egress from AXI4-Stream back-pressure; holds up to DEPTH flits.
//  Optional store-and-forward mode releases a packet only once its tail flit is buffered.
// PARAMETERS
//  FLIT_WIDTH         `FLIT_WIDTH  flit width: [W-1] valid, [W-2] tail, [W-3:W-4] dst, [W-5] vc, data below
//  DEPTH              8            entries; power of two, >= 2
//  STORE_AND_FORWARD  0            1: hold packet output until its tail is stored (or buffer full)
// PORTS
//  CLK             in   1              clock, all state on rising edge
//  RST_N           in   1              reset; asynchronous, active-low
//  in_flit         in   FLIT_WIDTH     flit from OutPortSimple
//  in_flit_valid   in   1              in_flit valid
//  in_flit_ready   out  1              buffer can accept a flit
//  out_flit        out  FLIT_WIDTH     head flit to AXI4-Stream slave bridge
//  out_flit_valid  out  1              out_flit valid
//  out_flit_ready  in   1              downstream accepts out_flit
//  level           out  $clog2(DEPTH)+1  flits currently stored
//  pkt_count       out  $clog2(DEPTH)+1  complete packets (tail stored, not yet popped)
//  oversize_err    out  1              sticky: packet longer than DEPTH seen in store-and-forward
// BEHAVIOUR
//  Reset (RST_N low, async): pointers, level, pkt_count, oversize_err = 0; state WAIT;
//   in_flit_ready = 0 while RST_N low, 1 from first cycle after release; out_flit_valid = 0.
//  Push when in_flit_valid && in_flit_ready; flit stored with bit [W-1] forced to 1.
//  Pop when out_flit_valid && out_flit_ready; out_flit = storage[rd_ptr] (combinational read).
//  in_flit_ready = (level != DEPTH); independent of out_flit_ready (no comb path in->out).
//  No bypass: flit pushed in cycle N is first visible on out_flit_valid in cycle N+1.
//  Push and pop same cycle: level unchanged; allowed when full only if ready was high (it is not).
//  Pointers width $clog2(DEPTH), wrap DEPTH-1 -> 0 naturally.
//  pkt_count: +1 on push of tail flit, -1 on pop of tail flit; both same cycle -> unchanged.
//  STORE_AND_FORWARD=0: out_flit_valid = (level != 0); FSM unused (stays WAIT).
//  STORE_AND_FORWARD=1, FSM on output side:
//   WAIT : out_flit_valid = 0 unless pkt_count != 0 or level == DEPTH.
//          -> DRAIN when (pkt_count != 0) or (level == DEPTH); if via full with pkt_count==0,
//             set oversize_err (cut-through for rest of that packet).
//   DRAIN: out_flit_valid = (level != 0); -> WAIT on pop of tail flit.
//   Valid decision uses registered state/counters: entering DRAIN from WAIT is a 1-cycle
//   transition, first pop possible in the cycle after the tail push + 1.
//  Once out_flit_valid is high, out_flit and out_flit_valid hold until popped (AXI-style).
//  Reset mid-packet discards all buffered flits; no partial state survives.
//  oversize_err clears only on reset.
// TESTING
//  S1 cut-through: push 1 flit tail=1 data=0x1234 at cycle 0, out_ready=1 -> out_flit_valid
//     at cycle 1, out data 0x1234, level 1->0, pkt_count 1->0.
//  S2 fill: DEPTH=8, out_ready=0, push 10 flits -> in_flit_ready low after 8th, level=8,
//     flits 9/10 held upstream; release out_ready -> 10 flits in order, none lost or duplicated.
//  S3 store-and-forward: 3-flit packet pushed one per 2 cycles -> out_flit_valid stays 0 until
//     cycle after tail push; then 3 pops back-to-back; FSM returns to WAIT after tail pop.
//  S4 oversize: S&F, 12-flit packet, DEPTH=8 -> oversize_err=1 when level hits 8, all 12
//     delivered in order, oversize_err remains 1.
//  S5 simultaneous push/pop at level 4 with tail in and tail out -> level stays 4, pkt_count unchanged.
//  S6 async reset asserted mid-packet (level 5) -> outputs zero immediately; after release
//     level=0, out_flit_valid=0, next packet passes correctly.

Source files
------------

// File: rtl/axis_flit_rx_buffer.sv
// Flit FIFO between the NoC receive port and the AXI4-Stream slave bridge, with an
// optional store-and-forward gate that holds a packet until its tail is buffered.
module axis_flit_rx_buffer #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEPTH             = 8,
  parameter bit STORE_AND_FORWARD = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [FLIT_WIDTH-1:0]  in_flit,
  input  logic                   in_flit_valid,
  output logic                   in_flit_ready,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic                   out_flit_valid,
  input  logic                   out_flit_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   oversize_err
);

  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = AW + 1;
  localparam int TAIL_BIT = FLIT_WIDTH - 2;
  localparam logic [LW-1:0]         FULL_LVL   = LW'(DEPTH);
  localparam logic [FLIT_WIDTH-1:0] VALID_MASK = {1'b1, {(FLIT_WIDTH-1){1'b0}}};

  typedef enum logic {S_WAIT = 1'b0, S_DRAIN = 1'b1} state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [FLIT_WIDTH-1:0] head;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rdy_en;
  state_t                state_q;
  state_t                state_d;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  push_tail;
  logic                  pop_tail;
  logic                  release_ok;
  logic                  oversize_set;

  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr];
  // rdy_en keeps the input closed while reset is held and opens on the first edge after
  assign in_flit_ready = rdy_en && !full;
  assign push       = in_flit_valid && in_flit_ready;
  assign pop        = out_flit_valid && out_flit_ready;
  assign push_tail  = push && in_flit[TAIL_BIT];
  assign pop_tail   = pop && head[TAIL_BIT];
  assign release_ok = (pkt_count != '0) || full;
  // A full buffer with no complete packet can only be an oversize packet; cut it through.
  assign oversize_set = STORE_AND_FORWARD && (state_q == S_WAIT) && full && (pkt_count == '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_flit | VALID_MASK;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pkt_count    <= '0;
      oversize_err <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (!push && pop) begin
        level <= level - LW'(1);
      end
      if (push_tail && !pop_tail) begin
        pkt_count <= pkt_count + LW'(1);
      end else if (!push_tail && pop_tail) begin
        pkt_count <= pkt_count - LW'(1);
      end
      if (oversize_set) begin
        oversize_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (STORE_AND_FORWARD) begin
      case (state_q)
        // A tail popped straight out of WAIT already finished its packet.
        S_WAIT:  if (release_ok && !pop_tail) state_d = S_DRAIN;
        S_DRAIN: if (pop_tail) state_d = S_WAIT;
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_comb begin
    out_flit_valid = !empty;
    if (STORE_AND_FORWARD && (state_q == S_WAIT)) begin
      out_flit_valid = release_ok;
    end
  end

  assign out_flit = out_flit_valid ? head : '0;

endmodule
